// File: rtl/fake_psx_pkg.sv
// Shared constants and the response-byte lookup for the fake digital PSX pad.
package fake_psx_pkg;

  typedef logic [2:0] pad_state_t;

  localparam pad_state_t ST_IDLE      = 3'd0;
  localparam pad_state_t ST_SHIFT     = 3'd1;
  localparam pad_state_t ST_ACK_WAIT  = 3'd2;
  localparam pad_state_t ST_ACK_PULSE = 3'd3;
  localparam pad_state_t ST_DONE      = 3'd4;
  localparam pad_state_t ST_IGNORE    = 3'd5;

  localparam logic [7:0] START_CMD    = 8'h01;
  localparam logic [7:0] BEGIN_TX_CMD = 8'h42;
  localparam logic [7:0] PREAMBLE     = 8'h5A;
  localparam logic [7:0] IDLE_BYTE    = 8'hFF;

  localparam int FRAME_BYTES = 5;

  function automatic logic [7:0] resp_byte(input logic [2:0] idx,
                                           input logic [7:0] pad_id,
                                           input logic [15:0] btn);
    case (idx)
      3'd0:    resp_byte = IDLE_BYTE;
      3'd1:    resp_byte = pad_id;
      3'd2:    resp_byte = PREAMBLE;
      3'd3:    resp_byte = btn[7:0];
      3'd4:    resp_byte = btn[15:8];
      default: resp_byte = IDLE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/psx_sync.sv
// Two-flop synchronizer for an idle-high console line, with registered edge detect.
module psx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      sync_p2 <= 1'b1;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign q    = sync_p1;
  assign rise = sync_p1 & ~sync_p2;
  assign fall = ~sync_p1 & sync_p2;

endmodule

// File: rtl/fake_psx_pad.sv
// Responder end of the console/pad serial link: answers the 5-byte digital poll
// with ID, preamble and a snapshot of the button word, acking every byte but the last.
module fake_psx_pad
  import fake_psx_pkg::*;
#(
  parameter int         ACK_DELAY = 4,
  parameter int         ACK_WIDTH = 4,
  parameter logic [7:0] PAD_ID    = 8'h41
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        att,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic [15:0] buttons,
  output logic        dat,
  output logic        ack,
  output logic        frame_done
);

  localparam int CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic att_lvl_unused, att_rise, att_fall;
  logic clk_lvl_unused, clk_rise, clk_fall;
  logic cmd_s, cmd_rise_unused, cmd_fall_unused;

  psx_sync u_att_sync (.clk(clk), .rst_n(rst_n), .d(att),
                       .q(att_lvl_unused), .rise(att_rise), .fall(att_fall));
  psx_sync u_clk_sync (.clk(clk), .rst_n(rst_n), .d(psx_clk),
                       .q(clk_lvl_unused), .rise(clk_rise), .fall(clk_fall));
  psx_sync u_cmd_sync (.clk(clk), .rst_n(rst_n), .d(cmd),
                       .q(cmd_s), .rise(cmd_rise_unused), .fall(cmd_fall_unused));

  pad_state_t       state;
  logic [2:0]       byte_idx;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       rx_byte;
  logic [15:0]      btn_latch;

  logic [7:0] tx_byte, tx_next, rx_full;
  logic       cmd_bad;

  assign tx_byte = resp_byte(byte_idx, PAD_ID, btn_latch);
  assign tx_next = resp_byte(byte_idx + 3'd1, PAD_ID, btn_latch);
  // The 8th command bit is still on cmd_s when the byte is judged.
  assign rx_full = {cmd_s, rx_byte};
  assign cmd_bad = ((byte_idx == 3'd0) && (rx_full != START_CMD)) ||
                   ((byte_idx == 3'd1) && (rx_full != BEGIN_TX_CMD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      byte_idx   <= 3'd0;
      bit_cnt    <= 3'd0;
      cnt        <= '0;
      rx_byte    <= '0;
      btn_latch  <= 16'hFFFF;
      dat        <= 1'b1;
      ack        <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (att_rise) begin
        state    <= ST_IDLE;
        byte_idx <= 3'd0;
        bit_cnt  <= 3'd0;
        cnt      <= '0;
        dat      <= 1'b1;
        ack      <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            dat <= 1'b1;
            ack <= 1'b1;
            if (att_fall) begin
              state    <= ST_SHIFT;
              byte_idx <= 3'd0;
              bit_cnt  <= 3'd0;
            end
          end
          ST_SHIFT: begin
            if (clk_fall) begin
              dat <= tx_byte[bit_cnt];
            end else if (clk_rise) begin
              rx_byte <= {cmd_s, rx_byte[6:1]};
              if (bit_cnt == 3'd7) begin
                bit_cnt <= 3'd0;
                cnt     <= '0;
                dat     <= 1'b1;
                if (byte_idx == 3'd2) btn_latch <= buttons;
                if (cmd_bad)                                state <= ST_IGNORE;
                else if (byte_idx == 3'(FRAME_BYTES - 1)) state <= ST_DONE;
                else                                        state <= ST_ACK_WAIT;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          ST_ACK_WAIT, ST_ACK_PULSE: begin
            if (clk_fall) begin
              // Console did not wait for ack: move straight into the next byte.
              ack      <= 1'b1;
              byte_idx <= byte_idx + 3'd1;
              cnt      <= '0;
              dat      <= tx_next[0];
              state    <= ST_SHIFT;
            end else if (state == ST_ACK_WAIT) begin
              if (cnt == CNT_W'(ACK_DELAY - 1)) begin
                ack   <= 1'b0;
                cnt   <= '0;
                state <= ST_ACK_PULSE;
              end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              if (cnt == CNT_W'(ACK_WIDTH - 1)) begin
                ack      <= 1'b1;
                cnt      <= '0;
                byte_idx <= byte_idx + 3'd1;
                state    <= ST_SHIFT;
              end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          ST_DONE: begin
            dat <= 1'b1;
            ack <= 1'b1;
            if (cnt == '0) begin
              frame_done <= 1'b1;
              cnt        <= CNT_W'(1);
            end
          end
          ST_IGNORE: begin
            dat <= 1'b1;
            ack <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fake_psx_pad.sv
// Console-side bench for fake_psx_pad: drives polls, scoreboards dat bytes, ack pulses and frame_done.
module tb_fake_psx_pad;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        att     = 1'b1;
  logic        psx_clk = 1'b1;
  logic        cmd     = 1'b1;
  logic [15:0] buttons = 16'hFFFE;
  logic        dat, ack, frame_done;

  fake_psx_pad #(.ACK_DELAY(4), .ACK_WIDTH(4), .PAD_ID(8'h41)) dut (
    .clk(clk), .rst_n(rst_n), .att(att), .psx_clk(psx_clk), .cmd(cmd),
    .buttons(buttons), .dat(dat), .ack(ack), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { int start; int width; } ack_exp_t;
  logic [7:0] dat_q[$];
  ack_exp_t   ack_q[$];
  int         fd_q[$];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got an event, expected none (cycle %0d)", name, cyc);
  endtask

  // dat monitor: assembles one byte per 8 console rising edges
  initial begin : dat_mon
    logic [7:0] sh;
    int nb;
    sh = 8'h00;
    nb = 0;
    forever begin
      @(posedge psx_clk or posedge att);
      if (att) nb = 0;
      else begin
        sh[nb] = dat;
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (dat_q.size() == 0) flag_unexpected("dat_byte");
          else check("dat_byte", sh, dat_q.pop_front());
        end
      end
    end
  end

  // ack monitor: start cycle and width of each low pulse
  initial begin : ack_mon
    logic prev;
    int w;
    bit have_e;
    ack_exp_t e;
    prev = 1'b1;
    w = 0;
    have_e = 0;
    e = '{0, 0};
    forever begin
      @(negedge clk);
      if (prev && !ack) begin
        w = 0;
        if (ack_q.size() == 0) begin
          flag_unexpected("ack_start");
          have_e = 0;
        end else begin
          e = ack_q.pop_front();
          have_e = 1;
          check("ack_start", cyc, e.start);
        end
      end
      if (!ack) w++;
      if (!prev && ack && have_e) begin
        check("ack_width", w, e.width);
        have_e = 0;
      end
      prev = ack;
    end
  end

  initial begin : fd_mon
    forever begin
      @(negedge clk);
      if (frame_done) begin
        if (fd_q.size() == 0) flag_unexpected("frame_done");
        else check("frame_done_cycle", cyc, fd_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic send_bits(input logic [7:0] b, input int n, output int k);
    k = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psx_clk = 1'b0;
      cmd     = b[i];
      repeat (5) @(posedge clk);
      #1;
      psx_clk = 1'b1;
      k = cyc;
      repeat (4) @(posedge clk);
    end
  endtask

  // mode: 0 = no ack/frame_done, 1 = ack expected, 2 = frame_done expected
  task automatic send_byte(input logic [7:0] b, input logic [7:0] exp, input int mode,
                           input int ack_w, input int gap);
    int k;
    dat_q.push_back(exp);
    send_bits(b, 8, k);
    if (mode == 1) ack_q.push_back('{k + 7, ack_w});
    if (mode == 2) fd_q.push_back(k + 4);
    repeat (gap) @(posedge clk);
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    att = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic end_frame();
    repeat (4) @(posedge clk);
    #1;
    att = 1'b1;
    psx_clk = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic poll(input logic [15:0] bt);
    buttons = bt;
    start_frame();
    send_byte(8'h01, 8'hFF,     1, 4, 8);
    send_byte(8'h42, 8'h41,     1, 4, 8);
    send_byte(8'h00, 8'h5A,     1, 4, 8);
    send_byte(8'h00, bt[7:0],   1, 4, 8);
    send_byte(8'h00, bt[15:8],  2, 4, 8);
    end_frame();
  endtask

  initial begin : stim
    int k;
    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dat", dat, 1);
    check("reset_ack", ack, 1);
    check("reset_frame_done", frame_done, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    poll(16'hFFFE);

    // bad start command: pad ignores the whole frame
    start_frame();
    send_byte(8'h81, 8'hFF, 0, 0, 8);
    send_byte(8'h42, 8'hFF, 0, 0, 8);
    send_byte(8'h00, 8'hFF, 0, 0, 8);
    send_byte(8'h00, 8'hFF, 0, 0, 8);
    send_byte(8'h00, 8'hFF, 0, 0, 8);
    end_frame();

    poll(16'hA53C);

    // buttons change after the byte-2 snapshot
    buttons = 16'hFFFF;
    start_frame();
    send_byte(8'h01, 8'hFF, 1, 4, 8);
    send_byte(8'h42, 8'h41, 1, 4, 8);
    send_byte(8'h00, 8'h5A, 1, 4, 8);
    buttons = 16'h0000;
    send_byte(8'h00, 8'hFF, 1, 4, 8);
    send_byte(8'h00, 8'hFF, 2, 4, 8);
    end_frame();

    // attention dropped after 3 bits of byte 1
    buttons = 16'hFFFE;
    start_frame();
    send_byte(8'h01, 8'hFF, 1, 4, 8);
    send_bits(8'h42, 3, k);
    check("abort_dat_before", dat, 0);
    #1;
    att = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_dat", dat, 1);
    check("abort_ack", ack, 1);
    repeat (10) @(posedge clk);
    poll(16'h7FFE);

    // console clocks byte 1 while ack is still low
    buttons = 16'hFFFE;
    start_frame();
    send_byte(8'h01, 8'hFF, 1, 1, 0);
    send_byte(8'h42, 8'h41, 1, 4, 8);
    send_byte(8'h00, 8'h5A, 1, 4, 8);
    send_byte(8'h00, 8'hFE, 1, 4, 8);
    send_byte(8'h00, 8'hFF, 2, 4, 8);
    end_frame();

    // reset asserted one cycle into the ack pulse
    start_frame();
    send_byte(8'h01, 8'hFF, 1, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_ack", ack, 1);
    check("rst_async_dat", dat, 1);
    att = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_dat", dat, 1);
    check("post_rst_ack", ack, 1);
    poll(16'h1234);

    repeat (20) @(posedge clk);
    check("dat_q_drained", dat_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    check("fd_q_drained", fd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
